bus_slave_port: RTL
===================

Name: bus_slave_port

Overview:
- Responder end of the serial system-bus protocol. It sits between the bus interconnect and a local slave memory.
- It deserialises the address and write data a master shifts in, then performs one local memory access.
- For reads, it serialises the 8-bit result back to the master.
- The interconnect decodes the slave-select bits, so this block only sees frames already routed to it.

Parameters:
ADDR_WIDTH, 12, local address bits per frame (14-bit bus address minus 2 select bits)
DATA_WIDTH, 8, data bits per transfer
READ_LATENCY, 2, cycles from mem_re to mem_rdata valid (legal range 1..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
bus_valid  input  1  master is driving a frame bit this cycle
bus_rw  input  1  transfer type, sampled on the first frame cycle only (1=read, 0=write)
bus_sdata  input  1  serial address then write data, LSB first
slave_ready  output  1  high only in IDLE; slave can accept a new frame
slave_rvalid  output  1  slave_rdata carries a valid read-data bit
slave_rdata  output  1  serial read data, LSB first
frame_error  output  1  one-cycle pulse when a frame is aborted
mem_addr  output  ADDR_WIDTH  local memory address
mem_wdata  output  DATA_WIDTH  local write data
mem_we  output  1  one-cycle write strobe
mem_re  output  1  one-cycle read strobe
mem_rdata  input  DATA_WIDTH  local read data, valid READ_LATENCY cycles after mem_re

Behaviour:
- Reset (async, active-high): state=IDLE, slave_ready=1, all other outputs 0; address, data and bit counters cleared.
- All bit counts below use cycle 0 = the first cycle bus_valid=1 is seen in IDLE.
- IDLE:
  - If bus_valid=1: latch bus_rw, shift in address bit 0, go to ADDR.
  - slave_ready falls in the cycle after frame start.
- ADDR:
  - Shift one address bit per cycle (cycles 1..ADDR_WIDTH-1).
  - After the last bit: go to WDATA if write, MEM_READ if read.
- WDATA (write only): shift DATA_WIDTH bits, cycles 12..19 at default parameters.
- Abort: bus_valid=0 during ADDR or WDATA:
  - frame_error=1 for one cycle, return to IDLE.
  - No mem_we/mem_re issued; partial shift registers discarded.
- MEM_WRITE (cycle 20):
  - mem_we=1 for exactly one cycle, with mem_addr/mem_wdata holding the full values.
  - Then IDLE; slave_ready=1 in cycle 21.
- MEM_READ (cycle 12):
  - mem_re=1 for exactly one cycle with mem_addr valid.
  - Wait READ_LATENCY cycles.
  - Capture mem_rdata at the end of cycle 12+READ_LATENCY.
- RDATA:
  - Cycles 13+RL .. 20+RL: slave_rvalid=1, slave_rdata=captured bit i in cycle 13+RL+i.
  - Then IDLE; slave_ready=1 in cycle 21+RL.
- bus_valid, bus_rw and bus_sdata are ignored in MEM_WRITE, MEM_READ and RDATA. No abort is possible once the memory access has started.
- mem_addr and mem_wdata hold their last values between frames. mem_we and mem_re are never high simultaneously.
- bus_valid high in IDLE in the cycle immediately after a frame completes starts a new frame (back-to-back frames are legal).
- Counter widths: bit counter covers max(ADDR_WIDTH, DATA_WIDTH); latency counter is 3 bits.

Decomposition:
- Shared package bus_pkg:
  - state enum (IDLE, ADDR, WDATA, MEM_WRITE, MEM_READ, RDATA)
  - RW_READ/RW_WRITE constants
  - bus address split constants (2 select bits, 12 local bits)
- One natural sub-module: serial_shift_reg, a parameterised LSB-first shift register with load and shift-enable.
  - Instantiated three times: address in, write data in, read data out.

Test Plan:
- Write frame: addr=12'hA5C, data=8'h3E, bus_valid held 20 cycles -> mem_we=1 only in cycle 20 with mem_addr=12'hA5C, mem_wdata=8'h3E; slave_ready=1 in cycle 21.
- Read frame, READ_LATENCY=2: addr=12'h001, mem_rdata=8'hC5 -> mem_re only in cycle 12; slave_rvalid cycles 15..22, serial bits 1,0,1,0,0,0,1,1; ready in cycle 23.
- Abort: bus_valid dropped at cycle 7 of a write frame -> frame_error pulse, no mem_we/mem_re, slave_ready=1 next cycle; next full frame (addr=12'hFFF, data=8'hFF) completes correctly.
- Reset mid-RDATA (asserted after 3 bits) -> slave_rvalid=0 and slave_ready=1 immediately (asynchronous), no further strobes.
- Back-to-back: read frame followed immediately by write frame -> both accesses correct; bus_valid toggling during MEM_READ/RDATA ignored.
- Parameter sweep READ_LATENCY=1 and 7 -> rdata capture timing and slave_rvalid start shift by exactly RL.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the serial system-bus slave port.
package bus_pkg;
   typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEM_WRITE, MEM_READ, RDATA} state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   // 14-bit bus address: 2 select bits decoded upstream, 12 bits reach the slave
   localparam int BUS_ADDR_W   = 14;
   localparam int SEL_W        = 2;
   localparam int LOCAL_ADDR_W = BUS_ADDR_W - SEL_W;
endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first shift register: new bits enter at the MSB and move toward bit 0.
module serial_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift,
   input  logic         sin,
   output logic [W-1:0] q,
   output logic [W-1:0] nxt
);
   // nxt lets the owner grab the word in the same cycle the last bit arrives
   always_comb begin
      nxt = q;
      if (load)
         nxt = load_val;
      else if (shift)
         nxt = {sin, q[W-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else
         q <= nxt;
   end
endmodule

// File: rtl/bus_slave_port.sv
// Responder end of the serial system bus: deserialise a frame, do one local
// memory access, serialise read data back to the master.
module bus_slave_port
   import bus_pkg::*;
#(
   parameter int ADDR_WIDTH   = LOCAL_ADDR_W,
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bus_valid,
   input  logic                  bus_rw,
   input  logic                  bus_sdata,
   output logic                  slave_ready,
   output logic                  slave_rvalid,
   output logic                  slave_rdata,
   output logic                  frame_error,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);
   localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W = $clog2(MAX_W + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       lat;
   logic             rw;

   logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt, rd_q, rd_nxt;
   logic addr_shift, wdata_shift, capture, rd_shift;

   assign addr_shift  = bus_valid && (state == IDLE || state == ADDR);
   assign wdata_shift = bus_valid && (state == WDATA);
   assign capture     = (state == MEM_READ) && (lat == 3'(READ_LATENCY));
   assign rd_shift    = (state == RDATA);

   serial_shift_reg #(.W(ADDR_WIDTH)) u_addr (
      .clk(clk), .reset(reset), .load(1'b0), .load_val('0),
      .shift(addr_shift), .sin(bus_sdata), .q(addr_q), .nxt(addr_nxt)
   );

   serial_shift_reg #(.W(DATA_WIDTH)) u_wdata (
      .clk(clk), .reset(reset), .load(1'b0), .load_val('0),
      .shift(wdata_shift), .sin(bus_sdata), .q(wdata_q), .nxt(wdata_nxt)
   );

   serial_shift_reg #(.W(DATA_WIDTH)) u_rdata (
      .clk(clk), .reset(reset), .load(capture), .load_val(mem_rdata),
      .shift(rd_shift), .sin(1'b0), .q(rd_q), .nxt(rd_nxt)
   );

   assign slave_rdata = slave_rvalid & rd_q[0];

   logic unused_bits;
   assign unused_bits = ^{wdata_q, rd_q[DATA_WIDTH-1:1], rd_nxt};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         lat          <= '0;
         rw           <= 1'b0;
         slave_ready  <= 1'b1;
         slave_rvalid <= 1'b0;
         frame_error  <= 1'b0;
         mem_we       <= 1'b0;
         mem_re       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         frame_error <= 1'b0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
         case (state)
            IDLE: if (bus_valid) begin
               rw          <= bus_rw;
               cnt         <= CNT_W'(1);
               state       <= ADDR;
               slave_ready <= 1'b0;
            end
            ADDR: if (!bus_valid) begin
               state       <= IDLE;
               cnt         <= '0;
               frame_error <= 1'b1;
               slave_ready <= 1'b1;
            end else if (cnt == CNT_W'(ADDR_WIDTH - 1)) begin
               cnt <= '0;
               if (rw == RW_READ) begin
                  state    <= MEM_READ;
                  mem_re   <= 1'b1;
                  mem_addr <= addr_nxt;
                  lat      <= '0;
               end else begin
                  state <= WDATA;
               end
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
            WDATA: if (!bus_valid) begin
               state       <= IDLE;
               cnt         <= '0;
               frame_error <= 1'b1;
               slave_ready <= 1'b1;
            end else if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
               cnt       <= '0;
               state     <= MEM_WRITE;
               mem_we    <= 1'b1;
               mem_addr  <= addr_q;
               mem_wdata <= wdata_nxt;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
            MEM_WRITE: begin
               state       <= IDLE;
               slave_ready <= 1'b1;
            end
            MEM_READ: if (capture) begin
               state        <= RDATA;
               slave_rvalid <= 1'b1;
            end else begin
               lat <= lat + 3'd1;
            end
            RDATA: if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
               cnt          <= '0;
               state        <= IDLE;
               slave_rvalid <= 1'b0;
               slave_ready  <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
            default: begin
               state       <= IDLE;
               slave_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule
